pulse_period_meter: RTL and testbench

- Receive-side counterpart of the periodic pulse generator.
- Accepts a stream of single-cycle pulses and measures the number of idle cycles between consecutive pulses.
- Reports each measurement with a valid strobe, flags timeouts, and indicates when the period is stable.
- Used to check generator output in hardware and to measure encoder/button tick rates in the etch-a-sketch datapath.

---
 rtl/pulse_period_meter.sv | 95 +++++++++
 tb/tb_pulse_period_meter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures idle cycles between consecutive single-cycle pulses, with a valid strobe,
// a timeout strobe when no pulse follows within 2^N cycles, and a stable-period flag.
module pulse_period_meter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         overflow,
  output logic         stable
);

  typedef enum logic {S_IDLE, S_MEASURE} state_t;

  localparam logic [N-1:0] CNT_MAX = '1;

  state_t       state, state_nxt;
  logic [N-1:0] count, count_nxt;
  logic [N-1:0] period_nxt;
  logic         valid_nxt, overflow_nxt, stable_nxt;
  // Set once a measurement has completed since the last arm; gates the stable flag.
  logic         hist, hist_nxt;

  function automatic logic at_limit(input logic [N-1:0] c);
    return c == CNT_MAX;
  endfunction

  function automatic logic [N-1:0] count_inc(input logic [N-1:0] c);
    return c + {{(N-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= '0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      stable   <= 1'b0;
      hist     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      period   <= period_nxt;
      valid    <= valid_nxt;
      overflow <= overflow_nxt;
      stable   <= stable_nxt;
      hist     <= hist_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    period_nxt   = period;
    valid_nxt    = 1'b0;
    overflow_nxt = 1'b0;
    stable_nxt   = stable;
    hist_nxt     = hist;
    if (ena) begin
      unique case (state)
        S_IDLE: begin
          count_nxt = '0;
          if (pulse_in) begin
            state_nxt = S_MEASURE;
            hist_nxt  = 1'b0;
          end
        end
        S_MEASURE: begin
          if (pulse_in) begin
            // A pulse at the limit is still a measurement, never a timeout.
            period_nxt = count;
            valid_nxt  = 1'b1;
            count_nxt  = '0;
            stable_nxt = (count == period) && hist;
            hist_nxt   = 1'b1;
          end else if (at_limit(count)) begin
            overflow_nxt = 1'b1;
            stable_nxt   = 1'b0;
            hist_nxt     = 1'b0;
            count_nxt    = '0;
            state_nxt    = S_IDLE;
          end else begin
            count_nxt = count_inc(count);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: scoreboard of expected strobes checked by a
// negedge monitor, plus immediate checks of reset, ena and timeout behaviour.
module tb_pulse_period_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       pulse_in = 1'b0;
  logic       use_n4 = 1'b0;

  logic [7:0] period8;
  logic       valid8, overflow8, stable8;
  logic [3:0] period4;
  logic       valid4, overflow4, stable4;

  logic [7:0] s_period;
  logic       s_valid, s_overflow, s_stable;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [7:0] period;
    logic       ovf;
    logic       chk_stable;
    logic       stable;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pulse_period_meter #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
    .period(period8), .valid(valid8), .overflow(overflow8), .stable(stable8)
  );

  pulse_period_meter #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
    .period(period4), .valid(valid4), .overflow(overflow4), .stable(stable4)
  );

  assign s_period   = use_n4 ? {4'b0000, period4} : period8;
  assign s_valid    = use_n4 ? valid4    : valid8;
  assign s_overflow = use_n4 ? overflow4 : overflow8;
  assign s_stable   = use_n4 ? stable4   : stable8;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] per, input logic ovf,
                      input logic chk_st, input logic st);
    exp_t e;
    e.tag = tag; e.period = per; e.ovf = ovf; e.chk_stable = chk_st; e.stable = st;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    pulse_in = 1'b0;
    rst = 1'b0;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b1;
    tick(1'b0);
  endtask

  // Monitor: every strobe from the selected instance must match the next expectation.
  always @(negedge clk) begin
    if (rst && (s_valid || s_overflow)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {14'b0, s_valid, s_overflow}, 16'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_valid"}, {15'b0, s_valid}, {15'b0, !e.ovf});
        check({e.tag, "_overflow"}, {15'b0, s_overflow}, {15'b0, e.ovf});
        check({e.tag, "_period"}, {8'b0, s_period}, {8'b0, e.period});
        if (e.chk_stable) check({e.tag, "_stable"}, {15'b0, s_stable}, {15'b0, e.stable});
      end
    end
  end

  initial begin
    // Reset and arm
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_period8", {8'b0, period8}, 16'h0);
    check("rst_valid8", {15'b0, valid8}, 16'h0);
    check("rst_overflow8", {15'b0, overflow8}, 16'h0);
    check("rst_stable8", {15'b0, stable8}, 16'h0);
    check("rst_period4", {12'b0, period4}, 16'h0);
    rst = 1'b1;
    tick(1'b0);
    tick(1'b1);
    check("arm_valid", {15'b0, valid8}, 16'h0);
    check("arm_period", {8'b0, period8}, 16'h0);
    check("arm_stable", {15'b0, stable8}, 16'h0);
    tick(1'b0);

    // Generator round-trip: pulses every 6 cycles measure as 5
    do_reset();
    tick(1'b1);
    for (int k = 1; k <= 5; k++) begin
      repeat (5) tick(1'b0);
      push($sformatf("gen%0d", k), 8'd5, 1'b0, (k != 2), (k >= 3));
      tick(1'b1);
    end
    tick(1'b0);
    check("gen_stable_hold", {15'b0, stable8}, 16'h1);

    // Back-to-back pulses
    do_reset();
    tick(1'b1);
    push("b2b1", 8'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b1);
    push("b2b2", 8'd0, 1'b0, 1'b1, 1'b1);
    tick(1'b1);
    push("b2b3", 8'd0, 1'b0, 1'b1, 1'b1);
    tick(1'b1);
    tick(1'b0);

    // Timeout on the N=4 instance
    use_n4 = 1'b1;
    do_reset();
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    push("to_meas", 8'd2, 1'b0, 1'b1, 1'b0);
    tick(1'b1);
    repeat (15) tick(1'b0);
    push("to_ovf", 8'd2, 1'b1, 1'b1, 1'b0);
    tick(1'b0);
    check("to_overflow", {15'b0, overflow4}, 16'h1);
    check("to_period_held", {12'b0, period4}, 16'h2);
    check("to_stable", {15'b0, stable4}, 16'h0);
    tick(1'b1);
    check("to_rearm_valid", {15'b0, valid4}, 16'h0);
    tick(1'b0);
    tick(1'b0);
    push("to_after", 8'd2, 1'b0, 1'b1, 1'b0);
    tick(1'b1);
    tick(1'b0);

    // Boundary: 15 idle cycles is a valid measurement of 15
    do_reset();
    tick(1'b1);
    repeat (15) tick(1'b0);
    push("bound", 8'd15, 1'b0, 1'b0, 1'b0);
    tick(1'b1);
    check("bound_no_ovf", {15'b0, overflow4}, 16'h0);
    check("bound_period", {12'b0, period4}, 16'hF);
    tick(1'b0);
    use_n4 = 1'b0;

    // ena freeze, then asynchronous reset mid-count
    do_reset();
    tick(1'b1);
    repeat (3) tick(1'b0);
    ena = 1'b0;
    repeat (4) tick(1'b1);
    check("ena_low_valid", {15'b0, valid8}, 16'h0);
    ena = 1'b1;
    tick(1'b0);
    tick(1'b0);
    push("ena_meas", 8'd5, 1'b0, 1'b1, 1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_period", {8'b0, period8}, 16'h0);
    check("async_rst_valid", {15'b0, valid8}, 16'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(1'b1);
    check("post_rst_arm_valid", {15'b0, valid8}, 16'h0);
    tick(1'b0);
    push("post_rst_meas", 8'd1, 1'b0, 1'b1, 1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);

    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
